// File: rtl/ex_mem_stage_if.sv
// ex_mem_stage_if -- bundle between the ID/EX register, the MEM/WB forwarding
// source and the EX/MEM register of the execute stage.
//
// Handshake: the stage has no valid/ready pair. 'stall' is the only flow
// control. While stall=1 the upstream stages hold PC, IF/ID and ID/EX, so every
// ID/EX field stays stable. When stall=0 the instruction on the ID/EX fields is
// consumed at the next posedge.
//
// Signals:
//   ID/EX      : ALUOp, RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg,
//                RsData, RtData, immediate (funct = immediate[5:0]),
//                RsAddr, RtAddr, RdAddr
//   MEM/WB     : wb_RegWrite, wb_WriteAddr, wb_WriteData (forwarding source)
//   EX/MEM     : ALUResult_out, WriteData_out, WriteAddr_out, RegWrite_out,
//                MemWrite_out, MemRead_out, MemToReg_out
//   flow/debug : stall (combinational), mulState (multiplier FSM state)
// Modports: master = upstream/environment side, slave = the execute stage.
interface ex_mem_stage_if;
    logic [1:0]  ALUOp;
    logic        RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg;
    logic [31:0] RsData, RtData, immediate;
    logic [4:0]  RsAddr, RtAddr, RdAddr;
    logic        wb_RegWrite;
    logic [4:0]  wb_WriteAddr;
    logic [31:0] wb_WriteData;
    logic [31:0] ALUResult_out, WriteData_out;
    logic [4:0]  WriteAddr_out;
    logic        RegWrite_out, MemWrite_out, MemRead_out, MemToReg_out;
    logic        stall;
    logic [1:0]  mulState;

    modport master (
        output ALUOp, RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg,
               RsData, RtData, immediate, RsAddr, RtAddr, RdAddr,
               wb_RegWrite, wb_WriteAddr, wb_WriteData,
        input  ALUResult_out, WriteData_out, WriteAddr_out, RegWrite_out,
               MemWrite_out, MemRead_out, MemToReg_out, stall, mulState
    );

    modport slave (
        input  ALUOp, RegDst, RegWrite, ALUSrc, MemWrite, MemRead, MemToReg,
               RsData, RtData, immediate, RsAddr, RtAddr, RdAddr,
               wb_RegWrite, wb_WriteAddr, wb_WriteData,
        output ALUResult_out, WriteData_out, WriteAddr_out, RegWrite_out,
               MemWrite_out, MemRead_out, MemToReg_out, stall, mulState
    );
endinterface

// File: rtl/ex_mem_stage.sv
// ex_mem_stage -- execute stage with operand forwarding, a single-cycle ALU,
// an iterative shift-add multiplier and the EX/MEM pipeline register.
//
// Ports:
//   clk   : clock, all state updates on posedge
//   rst_n : asynchronous active-low reset, clears outputs and the multiplier
//   bus   : ex_mem_stage_if.slave (ID/EX inputs, MEM/WB forward, EX/MEM outputs,
//           stall, mulState debug view)
module ex_mem_stage (
    input  logic           clk,
    input  logic           rst_n,
    ex_mem_stage_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} mulState_t;

    mulState_t   state;
    logic [4:0]  count;
    logic [31:0] mcand, mplier, product, mulRt;

    logic [5:0]  funct;
    logic        isMul;
    logic        exFwdA, exFwdB, wbFwdA, wbFwdB;
    logic [31:0] opA, fwdB, aluB, aluRes;
    logic [4:0]  destAddr;

    assign funct    = bus.immediate[5:0];
    assign isMul    = (bus.ALUOp == 2'b10) && (funct == 6'h18);
    assign destAddr = bus.RegDst ? bus.RdAddr : bus.RtAddr;

    // A load in EX/MEM has no data yet, so it is never an EX/MEM forward source.
    assign exFwdA = bus.RegWrite_out && (bus.WriteAddr_out != 5'd0) &&
                    (bus.WriteAddr_out == bus.RsAddr) && !bus.MemRead_out;
    assign exFwdB = bus.RegWrite_out && (bus.WriteAddr_out != 5'd0) &&
                    (bus.WriteAddr_out == bus.RtAddr) && !bus.MemRead_out;
    assign wbFwdA = bus.wb_RegWrite && (bus.wb_WriteAddr != 5'd0) &&
                    (bus.wb_WriteAddr == bus.RsAddr);
    assign wbFwdB = bus.wb_RegWrite && (bus.wb_WriteAddr != 5'd0) &&
                    (bus.wb_WriteAddr == bus.RtAddr);

    assign opA  = exFwdA ? bus.ALUResult_out : (wbFwdA ? bus.wb_WriteData : bus.RsData);
    assign fwdB = exFwdB ? bus.ALUResult_out : (wbFwdB ? bus.wb_WriteData : bus.RtData);
    assign aluB = bus.ALUSrc ? bus.immediate : fwdB;

    always_comb begin
        aluRes = 32'd0;
        case (bus.ALUOp)
            2'b00: aluRes = opA + aluB;
            2'b01: aluRes = opA - aluB;
            2'b11: aluRes = opA | aluB;
            default: begin
                case (funct)
                    6'h20: aluRes = opA + aluB;
                    6'h22: aluRes = opA - aluB;
                    6'h24: aluRes = opA & aluB;
                    6'h25: aluRes = opA | aluB;
                    6'h2A: aluRes = {31'd0, ($signed(opA) < $signed(aluB))};
                    default: aluRes = 32'd0;
                endcase
            end
        endcase
    end

    // Gated by rst_n so stall drops the instant reset is applied.
    assign bus.stall    = rst_n && (((state == IDLE) && isMul) || (state == BUSY));
    assign bus.mulState = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            count             <= 5'd0;
            mcand             <= 32'd0;
            mplier            <= 32'd0;
            product           <= 32'd0;
            mulRt             <= 32'd0;
            bus.ALUResult_out <= 32'd0;
            bus.WriteData_out <= 32'd0;
            bus.WriteAddr_out <= 5'd0;
            bus.RegWrite_out  <= 1'b0;
            bus.MemWrite_out  <= 1'b0;
            bus.MemRead_out   <= 1'b0;
            bus.MemToReg_out  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (isMul) begin
                        // Latch forwarded operands now; forwarding sources change
                        // while the bubbles drain through EX/MEM.
                        mcand            <= opA;
                        mplier           <= aluB;
                        mulRt            <= fwdB;
                        product          <= 32'd0;
                        count            <= 5'd0;
                        state            <= BUSY;
                        bus.RegWrite_out <= 1'b0;
                        bus.MemWrite_out <= 1'b0;
                        bus.MemRead_out  <= 1'b0;
                    end else begin
                        bus.ALUResult_out <= aluRes;
                        bus.WriteData_out <= fwdB;
                        bus.WriteAddr_out <= destAddr;
                        bus.RegWrite_out  <= bus.RegWrite;
                        bus.MemWrite_out  <= bus.MemWrite;
                        bus.MemRead_out   <= bus.MemRead;
                        bus.MemToReg_out  <= bus.MemToReg;
                    end
                end
                BUSY: begin
                    if (mplier[0]) begin
                        product <= product + mcand;
                    end
                    mcand            <= mcand << 1;
                    mplier           <= mplier >> 1;
                    count            <= count + 5'd1;
                    bus.RegWrite_out <= 1'b0;
                    bus.MemWrite_out <= 1'b0;
                    bus.MemRead_out  <= 1'b0;
                    if (count == 5'd31) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // ID/EX still holds the mul, so its controls are current.
                    bus.ALUResult_out <= product;
                    bus.WriteData_out <= mulRt;
                    bus.WriteAddr_out <= destAddr;
                    bus.RegWrite_out  <= bus.RegWrite;
                    bus.MemWrite_out  <= bus.MemWrite;
                    bus.MemRead_out   <= bus.MemRead;
                    bus.MemToReg_out  <= bus.MemToReg;
                    state             <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage -- directed bench for ex_mem_stage: a table of single-cycle
// vectors with hand-computed results, then multiply, reset and r0 sequences.
module tb_ex_mem_stage;
    logic clk;
    logic rst_n;
    int   passCnt = 0;
    int   totalCnt = 0;

    ex_mem_stage_if bus ();

    ex_mem_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0]  aluOp;
        logic        regDst, regWrite, aluSrc, memWrite, memRead, memToReg;
        logic [31:0] rs, rt, imm;
        logic [4:0]  rsA, rtA, rdA;
        logic        wbWe;
        logic [4:0]  wbA;
        logic [31:0] wbD;
        logic [31:0] expRes, expWd;
        logic [4:0]  expWa;
        logic [3:0]  expCtl;   // {RegWrite, MemWrite, MemRead, MemToReg}
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        bus.ALUOp        = v.aluOp;
        bus.RegDst       = v.regDst;
        bus.RegWrite     = v.regWrite;
        bus.ALUSrc       = v.aluSrc;
        bus.MemWrite     = v.memWrite;
        bus.MemRead      = v.memRead;
        bus.MemToReg     = v.memToReg;
        bus.RsData       = v.rs;
        bus.RtData       = v.rt;
        bus.immediate    = v.imm;
        bus.RsAddr       = v.rsA;
        bus.RtAddr       = v.rtA;
        bus.RdAddr       = v.rdA;
        bus.wb_RegWrite  = v.wbWe;
        bus.wb_WriteAddr = v.wbA;
        bus.wb_WriteData = v.wbD;
    endtask

    function automatic logic [3:0] ctl();
        return {bus.RegWrite_out, bus.MemWrite_out, bus.MemRead_out, bus.MemToReg_out};
    endfunction

    function automatic vec_t mk_mul(input logic [31:0] a, input logic [31:0] b,
                                    input logic [4:0] rsA, input logic [4:0] rtA,
                                    input logic [4:0] rdA);
        vec_t v;
        v = '{2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, a, b, 32'h18, rsA, rtA, rdA,
              1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 4'd0};
        return v;
    endfunction

    // Multiply: 33 stalled cycles, bubbles with held data for 33 edges,
    // result registered by edge 34. Called just after a posedge.
    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rsA, input logic [4:0] rtA, input logic [4:0] rdA,
                           input logic [31:0] expProd);
        int stallCycles;
        int bubbleBad;
        int holdBad;
        logic [31:0] heldRes;
        vec_t nop;
        stallCycles = 0;
        bubbleBad   = 0;
        holdBad     = 0;
        @(negedge clk);
        heldRes = bus.ALUResult_out;
        drive(mk_mul(a, b, rsA, rtA, rdA));
        #1;
        for (int e = 1; e <= 34; e++) begin
            if (bus.stall) stallCycles++;
            @(posedge clk);
            #1;
            if (e < 34) begin
                if (bus.RegWrite_out || bus.MemWrite_out || bus.MemRead_out) bubbleBad++;
                if (bus.ALUResult_out !== heldRes) holdBad++;
            end
        end
        check({tag, " stall cycles"}, stallCycles, 33);
        check({tag, " bubbles"}, bubbleBad, 0);
        check({tag, " data held in bubbles"}, holdBad, 0);
        check({tag, " product"}, bus.ALUResult_out, expProd);
        check({tag, " store data"}, bus.WriteData_out, b);
        check({tag, " dest"}, {27'd0, bus.WriteAddr_out}, {27'd0, rdA});
        check({tag, " RegWrite"}, {28'd0, ctl()}, 32'h8);
        // Move off the mul so it is not accepted again.
        nop = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0,
                5'd0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 4'd0};
        drive(nop);
        #1;
        check({tag, " stall after done"}, {31'd0, bus.stall}, 32'd0);
    endtask

    initial begin
        vec_t v;
        //        op    dst   rw    src   mw    mr    m2r   rs            rt            imm
        //        rsA   rtA   rdA   wbWe  wbA   wbD           expRes        expWd         expWa expCtl
        vecs[0]  = '{2'b10,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 32'd5,        32'd7,        32'h20,
                     5'd1, 5'd2, 5'd3, 1'b0,5'd0, 32'd0,        32'd12,       32'd7,        5'd3, 4'b1000};
        vecs[1]  = '{2'b01,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 32'd99,       32'd2,        32'h0,
                     5'd3, 5'd4, 5'd5, 1'b1,5'd3, 32'd50,       32'd10,       32'd2,        5'd5, 4'b1000};
        vecs[2]  = '{2'b00,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 32'd1,        32'd2,        32'h0,
                     5'd7, 5'd8, 5'd0, 1'b1,5'd7, 32'd100,      32'd102,      32'd2,        5'd8, 4'b1000};
        vecs[3]  = '{2'b00,1'b0,1'b1,1'b1,1'b0,1'b1,1'b1, 32'd0,        32'h55,       32'h10,
                     5'd8, 5'd9, 5'd0, 1'b0,5'd0, 32'd0,        32'd118,      32'h55,       5'd9, 4'b1011};
        vecs[4]  = '{2'b11,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 32'hF0,       32'h0F,       32'h0,
                     5'd9, 5'd0, 5'd10,1'b1,5'd9, 32'h300,      32'h30F,      32'h0F,       5'd10,4'b1000};
        vecs[5]  = '{2'b00,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0, 32'd0,        32'd1,        32'h4,
                     5'd10,5'd10,5'd0, 1'b0,5'd0, 32'd0,        32'h313,      32'h30F,      5'd10,4'b0100};
        vecs[6]  = '{2'b10,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 32'hFF00FF00, 32'h0FF00FF0, 32'h24,
                     5'd10,5'd11,5'd12,1'b0,5'd0, 32'd0,        32'h0F000F00, 32'h0FF00FF0, 5'd12,4'b1000};
        vecs[7]  = '{2'b10,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 32'd1,        32'd2,        32'h25,
                     5'd13,5'd14,5'd15,1'b0,5'd0, 32'd0,        32'd3,        32'd2,        5'd15,4'b1000};
        vecs[8]  = '{2'b10,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 32'd3,        32'd5,        32'h22,
                     5'd16,5'd17,5'd18,1'b0,5'd0, 32'd0,        32'hFFFFFFFE, 32'd5,        5'd18,4'b1000};
        vecs[9]  = '{2'b10,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 32'hFFFFFFFE, 32'd1,        32'h2A,
                     5'd19,5'd20,5'd0, 1'b0,5'd0, 32'd0,        32'd1,        32'd1,        5'd0, 4'b1000};
        vecs[10] = '{2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 32'd7,        32'd8,        32'h0,
                     5'd0, 5'd0, 5'd0, 1'b1,5'd0, 32'h999,      32'd15,       32'd8,        5'd0, 4'b0000};
        vecs[11] = '{2'b10,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 32'd5,        32'd6,        32'h3F,
                     5'd21,5'd22,5'd23,1'b0,5'd0, 32'd0,        32'd0,        32'd6,        5'd23,4'b1000};
        vecs[12] = '{2'b10,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 32'd5,        32'd3,        32'h2A,
                     5'd24,5'd25,5'd26,1'b0,5'd0, 32'd0,        32'd0,        32'd3,        5'd26,4'b1000};
        vecs[13] = '{2'b01,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 32'd0,        32'd1,        32'h0,
                     5'd27,5'd28,5'd29,1'b0,5'd0, 32'd0,        32'hFFFFFFFF, 32'd1,        5'd29,4'b1000};
        vecs[14] = '{2'b00,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0, 32'hFFFFFFFF, 32'd2,        32'h0,
                     5'd30,5'd31,5'd1, 1'b0,5'd0, 32'd0,        32'd1,        32'd2,        5'd1, 4'b1000};

        // Reset state.
        rst_n = 1'b0;
        drive(vecs[0]);
        #1;
        check("reset ALUResult", bus.ALUResult_out, 32'd0);
        check("reset WriteData", bus.WriteData_out, 32'd0);
        check("reset WriteAddr", {27'd0, bus.WriteAddr_out}, 32'd0);
        check("reset ctl", {28'd0, ctl()}, 32'd0);
        check("reset stall", {31'd0, bus.stall}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            #1;
            check($sformatf("v%0d stall", i), {31'd0, bus.stall}, 32'd0);
            @(posedge clk);
            #1;
            check($sformatf("v%0d ALUResult", i), bus.ALUResult_out, vecs[i].expRes);
            check($sformatf("v%0d WriteData", i), bus.WriteData_out, vecs[i].expWd);
            check($sformatf("v%0d WriteAddr", i), {27'd0, bus.WriteAddr_out}, {27'd0, vecs[i].expWa});
            check($sformatf("v%0d ctl", i), {28'd0, ctl()}, {28'd0, vecs[i].expCtl});
        end

        run_mul("mul1", 32'hFFFFFFFF, 32'd3, 5'd2, 5'd3, 5'd6, 32'hFFFFFFFD);
        run_mul("mul2", 32'h00012345, 32'h00000100, 5'd4, 5'd5, 5'd7, 32'h01234500);

        // Reset in the middle of a multiply (BUSY, count=10 after 11 edges).
        @(negedge clk);
        drive(mk_mul(32'd7, 32'd9, 5'd8, 5'd9, 5'd10));
        repeat (11) @(posedge clk);
        #1;
        check("midmul stall busy", {31'd0, bus.stall}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midmul reset ALUResult", bus.ALUResult_out, 32'd0);
        check("midmul reset WriteData", bus.WriteData_out, 32'd0);
        check("midmul reset WriteAddr", {27'd0, bus.WriteAddr_out}, 32'd0);
        check("midmul reset ctl", {28'd0, ctl()}, 32'd0);
        check("midmul reset stall", {31'd0, bus.stall}, 32'd0);
        check("midmul reset state", {30'd0, bus.mulState}, 32'd0);
        v = '{2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1, 32'd1, 32'd0,
              5'd1, 5'd2, 5'd3, 1'b0, 5'd0, 32'd0, 32'd0, 32'd0, 5'd0, 4'd0};
        drive(v);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post-reset add", bus.ALUResult_out, 32'd2);
        check("post-reset WriteAddr", {27'd0, bus.WriteAddr_out}, 32'd3);
        check("post-reset ctl", {28'd0, ctl()}, 32'h8);

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule
